data_memory_writer: RTL and testbench

//   Write-side counterpart of the Maxnet 4-word data memory.
//   - Accepts a serial stream of XLEN-bit words over a valid/ready handshake.
//   - Stores them in entries 0..3 in arrival order.
//   - Presents all four entries as parallel read ports, so it can replace the file-loaded memory in front of the Maxnet core.
//   - Signals full and a one-cycle done pulse when the fourth word lands.

---
 rtl/data_memory_writer.sv | 172 +++++++++++++++++
 tb/tb_data_memory_writer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_writer.sv
// -----------------------------------------------------------------------------
// data_memory_writer
//
// Write side of the Maxnet 4-word data memory. Words arrive one at a time over
// a valid/ready handshake and are stored in entries 0..3 in arrival order. All
// four entries are presented in parallel on readData1..4, so this block can
// stand in for the file-loaded memory in front of the Maxnet core.
//
// Parameters
//   XLEN       word width in bits
//   OVERWRITE  0: stall (in_ready=0) once four words are held
//              1: keep accepting and overwrite circularly from entry 0
//
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   clear      in   synchronous restart: empty buffer, zero entries
//   in_valid   in   in_data holds a word
//   in_data    in   word to store
//   in_ready   out  a word can be accepted this cycle
//   readData1  out  entry 0 (readData2..4 -> entries 1..3)
//   count      out  words stored, 0..4 (saturates at 4)
//   full       out  count == 4
//   done       out  one-cycle pulse after entry 3 is written
//   checksum   out  running XOR of accepted words (optional, see below)
//
// Optional feature macro: DATA_MEMORY_WRITER_CHECKSUM_EN
//   When defined, adds the checksum output and its accumulator.
//
// Every output comes from a register or a decode of registers only; nothing
// on in_* reaches an output combinationally.
// -----------------------------------------------------------------------------
module data_memory_writer #(
  parameter int XLEN      = 32,
  parameter bit OVERWRITE = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic            in_valid,
  input  logic [XLEN-1:0] in_data,
  output logic            in_ready,
  output logic [XLEN-1:0] readData1,
  output logic [XLEN-1:0] readData2,
  output logic [XLEN-1:0] readData3,
  output logic [XLEN-1:0] readData4,
  output logic [2:0]      count,
  output logic            full,
  output logic            done
`ifdef DATA_MEMORY_WRITER_CHECKSUM_EN
  ,
  output logic [XLEN-1:0] checksum
`endif
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_FILL  = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [1:0]      r_wr_ptr;
  logic            r_done;
  logic [XLEN-1:0] r_mem [4];
  logic            w_accept;

  assign w_accept = in_valid & in_ready;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic. clear wins over a same-cycle accept.
  // ---------------------------------------------------------------------------
  // NOTE: next state is defaulted to the current state before the case so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    if (clear) begin
      w_next_state = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: if (w_accept) w_next_state = S_FILL;
        S_FILL:  if (w_accept && (r_wr_ptr == 2'd3)) w_next_state = S_FULL;
        S_FULL:  w_next_state = S_FULL;
        default: w_next_state = S_EMPTY;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs, decoded from registers only.
  // In EMPTY the pointer is 0 and in FILL it equals the number of words held,
  // so count needs no register of its own.
  // ---------------------------------------------------------------------------
  always_comb begin
    full     = (r_state == S_FULL);
    in_ready = OVERWRITE ? 1'b1 : (r_state != S_FULL);
    count    = (r_state == S_FULL) ? 3'd4 : {1'b0, r_wr_ptr};
  end

  // ---------------------------------------------------------------------------
  // Write pointer and done pulse. The pointer wraps 3->0 naturally, which is
  // what makes overwrite mode circular. done fires whenever entry 3 is
  // written: the 4th word of a fill, or every 4th word while overwriting.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= 2'd0;
      r_done   <= 1'b0;
    end else if (clear) begin
      r_wr_ptr <= 2'd0;
      r_done   <= 1'b0;
    end else begin
      r_done <= w_accept && (r_wr_ptr == 2'd3);
      if (w_accept) begin
        r_wr_ptr <= r_wr_ptr + 2'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  // NOTE: the entries are reset on purpose: the read ports must show zero
  // immediately on reset, so this small array lives in flops, not a RAM macro.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) r_mem[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < 4; i++) r_mem[i] <= '0;
    end else if (w_accept) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

  assign readData1 = r_mem[0];
  assign readData2 = r_mem[1];
  assign readData3 = r_mem[2];
  assign readData4 = r_mem[3];
  assign done      = r_done;

`ifdef DATA_MEMORY_WRITER_CHECKSUM_EN
  // Running XOR of every accepted word, restarted by reset or clear.
  logic [XLEN-1:0] r_checksum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_checksum <= '0;
    end else if (clear) begin
      r_checksum <= '0;
    end else if (w_accept) begin
      r_checksum <= r_checksum ^ in_data;
    end
  end

  assign checksum = r_checksum;
`endif

endmodule

// File: tb/tb_data_memory_writer.sv
// -----------------------------------------------------------------------------
// tb_data_memory_writer
//
// Two instances share clock, reset, data and clear: u_dut0 (OVERWRITE=0) and
// u_dut1 (OVERWRITE=1), each with its own in_valid. A behavioural model of
// each pushes the expected post-edge view into a queue when a cycle is
// driven; the entry is popped and compared after the edge.
// -----------------------------------------------------------------------------
module tb_data_memory_writer;

  localparam int XLEN = 32;

  typedef struct {
    logic [XLEN-1:0] rd [4];
    logic [2:0]      cnt;
    logic            full;
    logic            done;
    logic            ready;
    logic [XLEN-1:0] csum;
  } snap_t;

  logic            clk   = 1'b0;
  logic            rst_n = 1'b0;
  logic            clear = 1'b0;
  logic            v0    = 1'b0;
  logic            v1    = 1'b0;
  logic [XLEN-1:0] data  = '0;

  logic [XLEN-1:0] rd0 [4];
  logic [XLEN-1:0] rd1 [4];
  logic [2:0]      cnt0, cnt1;
  logic            full0, full1, done0, done1, rdy0, rdy1;
  logic [XLEN-1:0] csum0, csum1;

  int checks = 0;
  int errors = 0;

  // Reference model state, index 0 = stall variant, 1 = overwrite variant
  logic [XLEN-1:0] m_e [2][4];
  int              m_ptr [2];
  int              m_cnt [2];
  logic            m_done [2];
  logic [XLEN-1:0] m_cs [2];
  bit              m_ow [2] = '{1'b0, 1'b1};

  snap_t q0[$];
  snap_t q1[$];

  always #5 clk = ~clk;

  data_memory_writer #(.XLEN(XLEN), .OVERWRITE(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(v0), .in_data(data),
    .in_ready(rdy0), .readData1(rd0[0]), .readData2(rd0[1]),
    .readData3(rd0[2]), .readData4(rd0[3]), .count(cnt0), .full(full0),
    .done(done0)
`ifdef DATA_MEMORY_WRITER_CHECKSUM_EN
    , .checksum(csum0)
`endif
  );

  data_memory_writer #(.XLEN(XLEN), .OVERWRITE(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(v1), .in_data(data),
    .in_ready(rdy1), .readData1(rd1[0]), .readData2(rd1[1]),
    .readData3(rd1[2]), .readData4(rd1[3]), .count(cnt1), .full(full1),
    .done(done1)
`ifdef DATA_MEMORY_WRITER_CHECKSUM_EN
    , .checksum(csum1)
`endif
  );

`ifndef DATA_MEMORY_WRITER_CHECKSUM_EN
  assign csum0 = '0;
  assign csum1 = '0;
`endif

  task automatic check(input string tag, input logic [XLEN-1:0] obs,
                       input logic [XLEN-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4; i++) m_e[k][i] = '0;
      m_ptr[k]  = 0;
      m_cnt[k]  = 0;
      m_done[k] = 1'b0;
      m_cs[k]   = '0;
    end
  endtask

  // One clock of the reference model for variant k.
  task automatic model_step(input int k, input logic v,
                            input logic [XLEN-1:0] d, input logic c);
    logic rdy;
    rdy = m_ow[k] || (m_cnt[k] != 4);
    if (c) begin
      for (int i = 0; i < 4; i++) m_e[k][i] = '0;
      m_ptr[k]  = 0;
      m_cnt[k]  = 0;
      m_done[k] = 1'b0;
      m_cs[k]   = '0;
    end else if (v && rdy) begin
      m_done[k]        = (m_ptr[k] == 3);   // entry 3 is being written
      m_e[k][m_ptr[k]] = d;
      m_cs[k]          = m_cs[k] ^ d;
      m_ptr[k]         = (m_ptr[k] + 1) % 4;
      if (m_cnt[k] < 4) m_cnt[k]++;
    end else begin
      m_done[k] = 1'b0;
    end
  endtask

  function automatic snap_t model_snap(input int k);
    snap_t s;
    for (int i = 0; i < 4; i++) s.rd[i] = m_e[k][i];
    s.cnt   = 3'(m_cnt[k]);
    s.full  = (m_cnt[k] == 4);
    s.done  = m_done[k];
    s.ready = m_ow[k] || (m_cnt[k] != 4);
    s.csum  = m_cs[k];
    return s;
  endfunction

  function automatic snap_t dut_snap(input int k);
    snap_t s;
    if (k == 0) begin
      for (int i = 0; i < 4; i++) s.rd[i] = rd0[i];
      s.cnt = cnt0; s.full = full0; s.done = done0; s.ready = rdy0;
      s.csum = csum0;
    end else begin
      for (int i = 0; i < 4; i++) s.rd[i] = rd1[i];
      s.cnt = cnt1; s.full = full1; s.done = done1; s.ready = rdy1;
      s.csum = csum1;
    end
    return s;
  endfunction

  task automatic check_snap(input string tag, input snap_t o, input snap_t e);
    for (int i = 0; i < 4; i++)
      check($sformatf("%s readData%0d", tag, i + 1), o.rd[i], e.rd[i]);
    check({tag, " count"}, XLEN'(o.cnt), XLEN'(e.cnt));
    check({tag, " full"},  XLEN'(o.full),  XLEN'(e.full));
    check({tag, " done"},  XLEN'(o.done),  XLEN'(e.done));
    check({tag, " in_ready"}, XLEN'(o.ready), XLEN'(e.ready));
`ifdef DATA_MEMORY_WRITER_CHECKSUM_EN
    check({tag, " checksum"}, o.csum, e.csum);
`endif
  endtask

  // Drive one cycle (called just after a falling edge), then compare at the
  // next falling edge.
  task automatic cycle(input string tag, input logic a0, input logic a1,
                       input logic [XLEN-1:0] d, input logic c);
    v0 = a0; v1 = a1; data = d; clear = c;
    model_step(0, a0, d, c);
    model_step(1, a1, d, c);
    q0.push_back(model_snap(0));
    q1.push_back(model_snap(1));
    @(posedge clk);
    @(negedge clk);
    v0 = 1'b0; v1 = 1'b0; clear = 1'b0; data = 32'hDEAD_BEEF;
    check_snap({tag, " ow0"}, dut_snap(0), q0.pop_front());
    check_snap({tag, " ow1"}, dut_snap(1), q1.pop_front());
  endtask

  task automatic check_now(input string tag);
    check_snap({tag, " ow0"}, dut_snap(0), model_snap(0));
    check_snap({tag, " ow1"}, dut_snap(1), model_snap(1));
  endtask

  initial begin
    model_reset();
    // Power-on reset, released on a falling edge
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 check_now("reset");

    // Fill back-to-back; 4th word: full and done together
    cycle("fill 11", 1, 1, 32'h11, 0);
    cycle("fill 22", 1, 1, 32'h22, 0);
    cycle("fill 33", 1, 1, 32'h33, 0);
    cycle("fill 44", 1, 1, 32'h44, 0);

    // Stall variant refuses 0xFF while full; done drops
    cycle("stall FF", 1, 0, 32'hFF, 0);

    // Overwrite variant: AA, BB land in entries 0,1 with no done
    cycle("ow AA", 1, 1, 32'hAA, 0);
    cycle("ow BB", 0, 1, 32'hBB, 0);
    cycle("ow CC", 0, 1, 32'hCC, 0);
    cycle("ow DD", 0, 1, 32'hDD, 0);   // entry 3 rewritten -> done
    cycle("idle",  0, 0, 32'h99, 0);

    // clear from full
    cycle("clear full", 0, 0, 32'h0, 1);

    // Two words, then clear racing a valid word: the word is dropped
    cycle("w 01", 1, 1, 32'h01, 0);
    cycle("w 02", 1, 1, 32'h02, 0);
    cycle("clear+55", 1, 1, 32'h55, 1);
    cycle("after clear", 0, 0, 32'h55, 0);

    // Partial fill with a gap in in_valid, then async reset mid-fill
    cycle("p A1", 1, 1, 32'hA1, 0);
    cycle("p gap", 0, 0, 32'hA5, 0);
    cycle("p A2", 1, 1, 32'hA2, 0);
    cycle("p A3", 1, 1, 32'hA3, 0);
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_now("async reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1 check_now("reset release");

    // Refill behaves like the first fill
    cycle("refill 11", 1, 1, 32'h11, 0);
    cycle("refill 22", 1, 1, 32'h22, 0);
    cycle("refill 33", 1, 1, 32'h33, 0);
    cycle("refill 44", 1, 1, 32'h44, 0);
    cycle("refill idle", 0, 0, 32'h0, 0);

    // Checksum sequence: 0F ^ F0 ^ FF ^ 01 = 01, then clear -> 0
    cycle("cs clear", 0, 0, 32'h0, 1);
    cycle("cs 0F", 1, 1, 32'h0F, 0);
    cycle("cs F0", 1, 1, 32'hF0, 0);
    cycle("cs FF", 1, 1, 32'hFF, 0);
    cycle("cs 01", 1, 1, 32'h01, 0);
`ifdef DATA_MEMORY_WRITER_CHECKSUM_EN
    check("cs value ow0", csum0, 32'h01);
    check("cs value ow1", csum1, 32'h01);
`endif
    cycle("cs clear2", 0, 0, 32'h0, 1);
`ifdef DATA_MEMORY_WRITER_CHECKSUM_EN
    check("cs cleared ow0", csum0, 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
